zx_fdd_mailbox: RTL and testbench

//  Buffered, flagged data channel between the ZX-side I/O port decode and the FDD-side Z80 strobes.

---
 rtl/zx_fdd_mailbox_pkg.sv | 33 +++
 rtl/zx_fdd_mailbox_fifo.sv | 100 ++++++++++
 rtl/zx_fdd_mailbox.sv | 160 ++++++++++++++++
 tb/tb_zx_fdd_mailbox.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/zx_fdd_mailbox_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zx_fdd_mailbox_pkg
//  Description : Shared constants and types for the ZX <-> FDD mailbox.
//                Holds the default bus width, the sticky error bit indices
//                and the strobe index enumeration that the top uses to
//                order its synchroniser instances.
//  Revision    : 1.0 - initial release
// ============================================================================
package zx_fdd_mailbox_pkg;

    // Default bus bits carried per transfer (D0, D1, D4-D7).
    localparam int DATA_W_DEF = 6;

    // Sticky error vector layout: {FDD_UNDR, FDD_OVR, ZX_UNDR, ZX_OVR}.
    localparam int ERR_W        = 4;
    localparam int ERR_ZX_OVR   = 0;
    localparam int ERR_ZX_UNDR  = 1;
    localparam int ERR_FDD_OVR  = 2;
    localparam int ERR_FDD_UNDR = 3;

    // Strobe order inside the synchroniser bank. All strobes are normalised
    // to active-high before entering the bank.
    localparam int NUM_STB = 4;
    typedef enum logic [1:0] {
        STB_ZX_WR  = 2'd0,
        STB_ZX_RD  = 2'd1,
        STB_FDD_WR = 2'd2,
        STB_FDD_RD = 2'd3
    } stb_e;

endpackage : zx_fdd_mailbox_pkg
`default_nettype wire

// File: rtl/zx_fdd_mailbox_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mbox_fifo
//  Description : Show-ahead FIFO for one mailbox direction. The registered
//                head (dout) always shows the oldest entry; once the FIFO
//                drains it keeps the last value popped.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                push, din         single-cycle write request and data
//                pop               single-cycle read-complete request
//                dout              registered head of FIFO
//                full, empty       occupancy status
//                ovr, undr         single-cycle error pulses (push on full,
//                                  pop on empty)
//  Revision    : 1.0 - initial release
// ============================================================================
module mbox_fifo #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              ovr,
    output logic              undr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d, count_after_pop;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              do_push, do_pop;

    always_comb begin
        // Pop is evaluated first so a push into a full FIFO can take the
        // slot the pop frees in the same cycle.
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != CNT_FULL) || do_pop);
        undr    = pop && (count_q == '0);
        ovr     = push && !do_push;

        rd_ptr_d = rd_ptr_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        wr_ptr_d = wr_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        count_after_pop = do_pop  ? (count_q - CNT_W'(1)) : count_q;
        count_d         = do_push ? (count_after_pop + CNT_W'(1)) : count_after_pop;

        // New head: an older stored entry if one survives the pop, otherwise
        // the word being pushed into an (effectively) empty FIFO, otherwise
        // hold the last value shown.
        dout_d = dout_q;
        if (count_after_pop != '0) begin
            dout_d = mem_q[rd_ptr_d];
        end else if (do_push) begin
            dout_d = din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = dout_q;
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

endmodule : mbox_fifo
`default_nettype wire

// File: rtl/zx_fdd_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : zx_fdd_mailbox
//  Description : Buffered, flagged data channel between the ZX-side port
//                decoder and the FDD-side Z80 strobes. Each direction is a
//                show-ahead FIFO; all strobes are synchronised into
//                CLK_16MHZ and edge detected.
//  Ports       : CLK_16MHZ, RST              clock, sync active-high reset
//                ZX_WR_STB / ZX_DIN          ZX push into ZX->FDD FIFO
//                ZX_RD_STB / ZX_DOUT         ZX pop from FDD->ZX FIFO
//                ZX_TX_FULL, ZX_RX_EMPTY     ZX-side status
//                nTIOUT / FDD_DIN            FDD push into FDD->ZX FIFO
//                nTIIN / FDD_DOUT            FDD pop from ZX->FDD FIFO
//                FDD_TX_FULL, FDD_RX_EMPTY   FDD-side status
//                CLR_ERR, ERR                sticky error flags and clear
//  Revision    : 1.0 - initial release
// ============================================================================
module zx_fdd_mailbox
    import zx_fdd_mailbox_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK_16MHZ,
    input  logic              RST,
    input  logic              ZX_WR_STB,
    input  logic              ZX_RD_STB,
    input  logic [DATA_W-1:0] ZX_DIN,
    output logic [DATA_W-1:0] ZX_DOUT,
    output logic              ZX_TX_FULL,
    output logic              ZX_RX_EMPTY,
    input  logic              nTIOUT,
    input  logic              nTIIN,
    input  logic [DATA_W-1:0] FDD_DIN,
    output logic [DATA_W-1:0] FDD_DOUT,
    output logic              FDD_TX_FULL,
    output logic              FDD_RX_EMPTY,
    input  logic              CLR_ERR,
    output logic [ERR_W-1:0]  ERR
);

    logic [NUM_STB-1:0] stb_raw;
    logic [NUM_STB-1:0] stb_ev;

    // Order follows stb_e; FDD strobes are active-low on the pins.
    assign stb_raw = {~nTIIN, ~nTIOUT, ZX_RD_STB, ZX_WR_STB};

    // Synchroniser + history flop per strobe. Neither is reset: the history
    // keeps following the synced level during RST, so a strobe held across
    // reset release never shows an assertion edge.
    for (genvar gi = 0; gi < NUM_STB; gi++) begin : g_strobe
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic                   hist_q, hist_d;
        logic                   lvl;
        logic                   rise;

        always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], stb_raw[gi]};
            lvl    = sync_q[SYNC_STAGES-1];
            hist_d = lvl;
            rise   = lvl & ~hist_q;
        end

        always_ff @(posedge CLK_16MHZ) begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end

        if ((gi == int'(STB_ZX_RD)) || (gi == int'(STB_FDD_RD))) begin : g_pop
            // A read is armed by its assertion edge and completes on the
            // deassertion edge, keeping DOUT stable for the whole bus read.
            // Arming is cleared by reset, so a read held through release
            // is ignored when it finally deasserts.
            logic armed_q, armed_d;
            logic fall;

            always_comb begin
                fall    = ~lvl & hist_q;
                armed_d = armed_q;
                if (rise) begin
                    armed_d = 1'b1;
                end else if (fall) begin
                    armed_d = 1'b0;
                end
            end

            always_ff @(posedge CLK_16MHZ) begin
                if (RST) begin
                    armed_q <= 1'b0;
                end else begin
                    armed_q <= armed_d;
                end
            end

            assign stb_ev[gi] = fall & armed_q;
        end else begin : g_push
            assign stb_ev[gi] = rise;
        end
    end

    logic zx2fdd_ovr, zx2fdd_undr;
    logic fdd2zx_ovr, fdd2zx_undr;

    mbox_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_zx2fdd (
        .clk   (CLK_16MHZ),
        .rst   (RST),
        .push  (stb_ev[STB_ZX_WR]),
        .pop   (stb_ev[STB_FDD_RD]),
        .din   (ZX_DIN),
        .dout  (FDD_DOUT),
        .full  (ZX_TX_FULL),
        .empty (FDD_RX_EMPTY),
        .ovr   (zx2fdd_ovr),
        .undr  (zx2fdd_undr)
    );

    mbox_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fdd2zx (
        .clk   (CLK_16MHZ),
        .rst   (RST),
        .push  (stb_ev[STB_FDD_WR]),
        .pop   (stb_ev[STB_ZX_RD]),
        .din   (FDD_DIN),
        .dout  (ZX_DOUT),
        .full  (FDD_TX_FULL),
        .empty (ZX_RX_EMPTY),
        .ovr   (fdd2zx_ovr),
        .undr  (fdd2zx_undr)
    );

    logic [ERR_W-1:0] err_q, err_d, err_new;

    always_comb begin
        err_new               = '0;
        err_new[ERR_ZX_OVR]   = zx2fdd_ovr;
        err_new[ERR_ZX_UNDR]  = fdd2zx_undr;
        err_new[ERR_FDD_OVR]  = fdd2zx_ovr;
        err_new[ERR_FDD_UNDR] = zx2fdd_undr;
        // A fresh error in the clearing cycle survives the clear.
        err_d = (err_q & ~{ERR_W{CLR_ERR}}) | err_new;
    end

    always_ff @(posedge CLK_16MHZ) begin
        if (RST) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR = err_q;

endmodule : zx_fdd_mailbox
`default_nettype wire

// File: tb/tb_zx_fdd_mailbox.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zx_fdd_mailbox
//  Description : Self-checking bench for zx_fdd_mailbox. A queue-based model
//                of both mailbox directions predicts every status/data output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zx_fdd_mailbox;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int DW    = 6;
    localparam int DEPTH = 4;

    logic          clk;
    logic          RST;
    logic          ZX_WR_STB, ZX_RD_STB, nTIOUT, nTIIN, CLR_ERR;
    logic [DW-1:0] ZX_DIN, FDD_DIN, ZX_DOUT, FDD_DOUT;
    logic          ZX_TX_FULL, ZX_RX_EMPTY, FDD_TX_FULL, FDD_RX_EMPTY;
    logic [3:0]    ERR;

    zx_fdd_mailbox #(.DATA_W(DW), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .CLK_16MHZ    (clk),
        .RST          (RST),
        .ZX_WR_STB    (ZX_WR_STB),
        .ZX_RD_STB    (ZX_RD_STB),
        .ZX_DIN       (ZX_DIN),
        .ZX_DOUT      (ZX_DOUT),
        .ZX_TX_FULL   (ZX_TX_FULL),
        .ZX_RX_EMPTY  (ZX_RX_EMPTY),
        .nTIOUT       (nTIOUT),
        .nTIIN        (nTIIN),
        .FDD_DIN      (FDD_DIN),
        .FDD_DOUT     (FDD_DOUT),
        .FDD_TX_FULL  (FDD_TX_FULL),
        .FDD_RX_EMPTY (FDD_RX_EMPTY),
        .CLR_ERR      (CLR_ERR),
        .ERR          (ERR)
    );

    initial clk = 1'b0;
    always #31.25 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per direction, the value each DOUT shows,
    // and the sticky error flags.
    logic [DW-1:0] zq[$];
    logic [DW-1:0] fq[$];
    logic [DW-1:0] zx_dout_m, fdd_dout_m;
    logic [3:0]    err_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ZX_DOUT"},      ZX_DOUT,      zx_dout_m);
        check({tag, ".FDD_DOUT"},     FDD_DOUT,     fdd_dout_m);
        check({tag, ".ZX_TX_FULL"},   ZX_TX_FULL,   zq.size() == DEPTH);
        check({tag, ".FDD_RX_EMPTY"}, FDD_RX_EMPTY, zq.size() == 0);
        check({tag, ".FDD_TX_FULL"},  FDD_TX_FULL,  fq.size() == DEPTH);
        check({tag, ".ZX_RX_EMPTY"},  ZX_RX_EMPTY,  fq.size() == 0);
        check({tag, ".ERR"},          ERR,          err_m);
    endtask

    task automatic m_reset();
        zq.delete();
        fq.delete();
        zx_dout_m  = '0;
        fdd_dout_m = '0;
        err_m      = '0;
    endtask

    // which: 0 ZX write, 1 ZX read, 2 FDD write, 3 FDD read
    task automatic m_op(input int which, input logic [DW-1:0] d);
        case (which)
            0: if (zq.size() == DEPTH) err_m[0] = 1'b1; else zq.push_back(d);
            1: if (fq.size() == 0) err_m[1] = 1'b1; else void'(fq.pop_front());
            2: if (fq.size() == DEPTH) err_m[2] = 1'b1; else fq.push_back(d);
            default: if (zq.size() == 0) err_m[3] = 1'b1; else void'(zq.pop_front());
        endcase
        if (zq.size() != 0) fdd_dout_m = zq[0];
        if (fq.size() != 0) zx_dout_m  = fq[0];
    endtask

    task automatic set_strobe(input int which, input logic active, input logic [DW-1:0] d);
        case (which)
            0: begin ZX_DIN = d; ZX_WR_STB = active; end
            1: ZX_RD_STB = active;
            2: begin FDD_DIN = d; nTIOUT = ~active; end
            default: nTIIN = ~active;
        endcase
    endtask

    // One full-width strobe (6 clocks) and gap, then compare everything.
    task automatic strobe(input int which, input logic [DW-1:0] d, input string tag);
        @(posedge clk); #5;
        set_strobe(which, 1'b1, d);
        repeat (6) @(posedge clk);
        #1;
        if (which == 1) check({tag, ".hold_ZX_DOUT"},  ZX_DOUT,  zx_dout_m);
        if (which == 3) check({tag, ".hold_FDD_DOUT"}, FDD_DOUT, fdd_dout_m);
        #4;
        set_strobe(which, 1'b0, d);
        m_op(which, d);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        @(posedge clk); #5;
        RST = 1'b1;
        repeat (4) @(posedge clk);
        #5;
        RST = 1'b0;
        m_reset();
    endtask

    int wz, rz, wf, rf, guard;

    initial begin
        RST = 1'b1; ZX_WR_STB = 1'b0; ZX_RD_STB = 1'b0; nTIOUT = 1'b1; nTIIN = 1'b1;
        CLR_ERR = 1'b0; ZX_DIN = '0; FDD_DIN = '0;
        m_reset();
        do_reset();
        @(negedge clk);
        check_all("reset");

        // 1: exact push/pop latency from the raw strobe edge
        @(posedge clk); #5;
        ZX_DIN = 6'h2A; ZX_WR_STB = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("t1.push_2clk_empty", FDD_RX_EMPTY, 1'b1);
        @(posedge clk); #1;
        check("t1.push_3clk_empty", FDD_RX_EMPTY, 1'b0);
        check("t1.push_3clk_dout",  FDD_DOUT,     6'h2A);
        m_op(0, 6'h2A);
        repeat (7) @(posedge clk); #5;
        ZX_WR_STB = 1'b0;
        repeat (6) @(posedge clk); #5;
        nTIIN = 1'b0;
        repeat (7) @(posedge clk); #5;
        nTIIN = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("t1.pop_2clk_empty", FDD_RX_EMPTY, 1'b0);
        @(posedge clk); #1;
        check("t1.pop_3clk_empty", FDD_RX_EMPTY, 1'b1);
        m_op(3, 6'h0);
        @(negedge clk);
        check_all("t1.end");

        // 2: fill ZX->FDD, overflow, drain
        for (int i = 1; i <= 5; i++) strobe(0, DW'(i), "t2.zxwr");
        for (int i = 0; i < 4; i++) strobe(3, '0, "t2.fddrd");

        // 3: ZX read of empty FDD->ZX, then clear errors
        strobe(1, '0, "t3.zxrd_empty");
        @(posedge clk); #5; CLR_ERR = 1'b1;
        @(posedge clk); #5; CLR_ERR = 1'b0;
        err_m = '0;
        @(negedge clk);
        check_all("t3.clr");

        // 4: full FDD->ZX, push and pop land on the same synced cycle
        for (int i = 0; i < 4; i++) strobe(2, DW'(6'h10 + i), "t4.fill");
        @(posedge clk); #5; ZX_RD_STB = 1'b1;
        repeat (6) @(posedge clk); #5;
        ZX_RD_STB = 1'b0; FDD_DIN = 6'h14; nTIOUT = 1'b0;
        m_op(1, '0);
        m_op(2, 6'h14);
        repeat (6) @(posedge clk); #5;
        nTIOUT = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_all("t4.aligned");
        for (int i = 0; i < 4; i++) strobe(1, '0, "t4.drain");

        // 5: FDD write held across reset release
        strobe(2, 6'h21, "t5.q");
        strobe(2, 6'h22, "t5.q");
        @(posedge clk); #5; RST = 1'b1;
        @(posedge clk); #5; FDD_DIN = 6'h30; nTIOUT = 1'b0;
        repeat (4) @(posedge clk); #5;
        RST = 1'b0;
        m_reset();
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_all("t5.after_rst");
        @(posedge clk); #5; nTIOUT = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_all("t5.released");
        strobe(2, 6'h3F, "t5.push3f");

        // 6: randomly interleaved traffic in both directions, no errors
        wz = 0; rz = 0; wf = 0; rf = 0; guard = 0;
        while ((rz < 64 || rf < 64) && guard < 4000) begin
            guard++;
            case ($urandom_range(0, 3))
                0: if (wz < 64 && zq.size() < DEPTH) begin strobe(0, DW'($urandom), "t6.zxwr"); wz++; end
                1: if (fq.size() > 0) begin strobe(1, '0, "t6.zxrd"); if (wf > 0) rf++; end
                2: if (wf < 64 && fq.size() < DEPTH) begin strobe(2, DW'($urandom), "t6.fddwr"); wf++; end
                default: if (zq.size() > 0) begin strobe(3, '0, "t6.fddrd"); rz++; end
            endcase
        end
        if (guard >= 4000) begin
            checks++;
            errors++;
            $error("FAIL t6.guard observed=%0d expected<4000", guard);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_zx_fdd_mailbox
`default_nettype wire
